// File: rtl/cu_sequencer.sv
// Control-step sequencer for the multi-cycle CPU control unit: holds the step
// register, applies ld/inc/clr commands, and adds run/halt, wait states and retire counting.
//
// step | meaning
// 0    | fetch1 (park point while halted)
// 1    | fetch2 (memory access)
// 2    | fetch3 (opcode sampled on ld)
// 3    | nop1   (also target of unmapped opcodes; returns to 0 unconditionally)
// 4-39 | instruction routines; 11, 16, 20 are memory steps
module cu_sequencer #(
    parameter int STATES = 40,
    parameter int OPW    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              counter_ld_i,
    input  logic              counter_inc_i,
    input  logic              counter_clr_i,
    input  logic [OPW-1:0]    opcode_i,
    input  logic              run_i,
    input  logic              step_i,
    input  logic              mem_ready_i,
    output logic [STATES-1:0] cpu_state_o,
    output logic [5:0]        state_idx_o,
    output logic              stall_o,
    output logic              halted_o,
    output logic              instr_done_o,
    output logic              illegal_op_o,
    output logic              protocol_err_o,
    output logic [15:0]       instr_count_o
);

    localparam logic [5:0] S_FETCH1  = 6'd0;
    localparam logic [5:0] S_FETCH2  = 6'd1;
    localparam logic [5:0] S_NOP1    = 6'd3;
    localparam logic [5:0] S_ALTLDR3 = 6'd11;
    localparam logic [5:0] S_STR4    = 6'd16;
    localparam logic [5:0] S_ALTSTR4 = 6'd20;
    localparam logic [5:0] S_LAST    = 6'(STATES - 1);

    logic [5:0]  state_q, state_d;
    logic        step_pending_q, step_pending_d;
    logic        instr_done_q, instr_done_d;
    logic        illegal_op_q, illegal_op_d;
    logic        protocol_err_q, protocol_err_d;
    logic [15:0] instr_count_q, instr_count_d;

    logic [5:0]  start_step;
    logic        op_mapped;
    logic        mem_step;
    logic        mem_wait;
    logic        halted;
    logic        multi_cmd;
    logic        perr_set;
    logic        retire;

    always_comb begin
        start_step = S_NOP1;
        op_mapped  = 1'b1;
        case (int'(opcode_i))
            0:       start_step = 6'd3;
            1:       start_step = 6'd4;
            2:       start_step = 6'd5;
            3:       start_step = 6'd7;
            4:       start_step = 6'd9;
            5:       start_step = 6'd13;
            6:       start_step = 6'd17;
            7:       start_step = 6'd21;
            8:       start_step = 6'd22;
            9:       start_step = 6'd23;
            10:      start_step = 6'd24;
            11:      start_step = 6'd25;
            12:      start_step = 6'd26;
            13:      start_step = 6'd28;
            14:      start_step = 6'd30;
            15:      start_step = 6'd32;
            16:      start_step = 6'd34;
            17:      start_step = 6'd36;
            18:      start_step = 6'd38;
            default: op_mapped  = 1'b0;
        endcase
    end

    assign mem_step  = (state_q == S_FETCH2) || (state_q == S_ALTLDR3) ||
                       (state_q == S_STR4)   || (state_q == S_ALTSTR4);
    assign mem_wait  = mem_step && !mem_ready_i;
    assign halted    = (state_q == S_FETCH1) && !run_i && !step_pending_q;
    assign multi_cmd = (counter_ld_i && counter_inc_i) || (counter_ld_i && counter_clr_i) ||
                       (counter_inc_i && counter_clr_i);

    // Commands are only evaluated (and only flagged) when the step actually listens to them.
    always_comb begin
        state_d      = state_q;
        illegal_op_d = 1'b0;
        perr_set     = 1'b0;
        if (mem_wait || halted) begin
            state_d = state_q;
        end else if (state_q == S_NOP1) begin
            state_d = S_FETCH1;
        end else begin
            perr_set = multi_cmd;
            if (counter_clr_i) begin
                state_d = S_FETCH1;
            end else if (counter_ld_i) begin
                state_d      = start_step;
                illegal_op_d = !op_mapped;
            end else if (counter_inc_i) begin
                if (state_q == S_LAST) begin
                    state_d  = S_FETCH1;
                    perr_set = 1'b1;
                end else begin
                    state_d = state_q + 6'd1;
                end
            end
        end
    end

    assign retire = (state_d == S_FETCH1) && (state_q >= S_NOP1);

    always_comb begin
        step_pending_d = step_pending_q;
        if ((state_q == S_FETCH1) && (state_d != S_FETCH1)) begin
            step_pending_d = 1'b0;
        end else if (halted && step_i) begin
            step_pending_d = 1'b1;
        end
        instr_done_d   = retire;
        instr_count_d  = retire ? instr_count_q + 16'd1 : instr_count_q;
        protocol_err_d = protocol_err_q || perr_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_FETCH1;
            step_pending_q <= 1'b0;
            instr_done_q   <= 1'b0;
            illegal_op_q   <= 1'b0;
            protocol_err_q <= 1'b0;
            instr_count_q  <= 16'd0;
        end else begin
            state_q        <= state_d;
            step_pending_q <= step_pending_d;
            instr_done_q   <= instr_done_d;
            illegal_op_q   <= illegal_op_d;
            protocol_err_q <= protocol_err_d;
            instr_count_q  <= instr_count_d;
        end
    end

    assign cpu_state_o    = {{(STATES-1){1'b0}}, 1'b1} << state_q;
    assign state_idx_o    = state_q;
    assign stall_o        = mem_wait;
    assign halted_o       = halted;
    assign instr_done_o   = instr_done_q;
    assign illegal_op_o   = illegal_op_q;
    assign protocol_err_o = protocol_err_q;
    assign instr_count_o  = instr_count_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed self-checking bench for cu_sequencer: fetch/execute flows, halt/step,
// wait states, illegal opcodes, protocol errors and reset behaviour.
module tb_cu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        counter_ld, counter_inc, counter_clr;
    logic [4:0]  opcode;
    logic        run, step, mem_ready;
    logic [39:0] cpu_state;
    logic [5:0]  state_idx;
    logic        stall, halted, instr_done, illegal_op, protocol_err;
    logic [15:0] instr_count;

    int n_cmp = 0;
    int n_err = 0;

    cu_sequencer #(.STATES(40), .OPW(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .counter_ld_i   (counter_ld),
        .counter_inc_i  (counter_inc),
        .counter_clr_i  (counter_clr),
        .opcode_i       (opcode),
        .run_i          (run),
        .step_i         (step),
        .mem_ready_i    (mem_ready),
        .cpu_state_o    (cpu_state),
        .state_idx_o    (state_idx),
        .stall_o        (stall),
        .halted_o       (halted),
        .instr_done_o   (instr_done),
        .illegal_op_o   (illegal_op),
        .protocol_err_o (protocol_err),
        .instr_count_o  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply commands, advance one clock, leave the bench 1 time unit past the edge.
    task automatic cyc(input logic ld, input logic inc, input logic clr, input logic [4:0] op);
        counter_ld  = ld;
        counter_inc = inc;
        counter_clr = clr;
        opcode      = op;
        @(posedge clk);
        #1;
    endtask

    int map_op  [17] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 13, 14, 15, 16, 17, 18};
    int map_exp [17] = '{4, 5, 7, 9, 13, 17, 21, 22, 23, 24, 25, 28, 30, 32, 34, 36, 38};
    int stalls;

    initial begin
        rst_n = 1'b0; run = 1'b1; step = 1'b0; mem_ready = 1'b1;
        counter_ld = 1'b0; counter_inc = 1'b0; counter_clr = 1'b0; opcode = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_state", cpu_state, 40'h1);
        chk("rst_count", instr_count, 0);
        chk("rst_stall", stall, 0);
        chk("rst_halted", halted, 0);
        chk("rst_perr", protocol_err, 0);
        rst_n = 1'b1;
        chk("rel_idx", state_idx, 0);

        // add: 0,1,2,26,27,0
        cyc(0, 1, 0, 0);  chk("add_idx1", state_idx, 1);
        cyc(0, 1, 0, 0);  chk("add_idx2", state_idx, 2);
        cyc(1, 0, 0, 12); chk("add_idx26", state_idx, 26);
        chk("add_onehot", cpu_state, 40'h1 << 26);
        chk("add_no_done", instr_done, 0);
        cyc(0, 1, 0, 0);  chk("add_idx27", state_idx, 27);
        cyc(0, 0, 1, 0);  chk("add_idx0", state_idx, 0);
        chk("add_done", instr_done, 1);
        chk("add_count", instr_count, 1);
        cyc(0, 0, 0, 0);  chk("add_done_clr", instr_done, 0);

        // nop: no commands in step 3
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);  chk("nop_idx3", state_idx, 3);
        chk("nop_no_ill", illegal_op, 0);
        cyc(0, 0, 0, 0);  chk("nop_idx0", state_idx, 0);
        chk("nop_done", instr_done, 1);
        chk("nop_count", instr_count, 2);

        // illegal opcode 25
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 25); chk("ill_idx3", state_idx, 3);
        chk("ill_pulse", illegal_op, 1);
        cyc(0, 0, 0, 0);  chk("ill_idx0", state_idx, 0);
        chk("ill_clr", illegal_op, 0);
        chk("ill_count", instr_count, 3);

        // halt at next fetch1, then single step
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 12); chk("hlt_idx26", state_idx, 26);
        run = 1'b0;
        cyc(0, 1, 0, 0);  chk("hlt_idx27", state_idx, 27);
        chk("hlt_not_yet", halted, 0);
        cyc(0, 0, 1, 0);  chk("hlt_idx0", state_idx, 0);
        chk("hlt_halted", halted, 1);
        chk("hlt_count", instr_count, 4);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 0, 0);
            chk("hlt_hold", state_idx, 0);
        end
        chk("hlt_still", halted, 1);
        step = 1'b1;
        cyc(0, 0, 0, 0);
        step = 1'b0;
        chk("stp_released", halted, 0);
        cyc(0, 1, 0, 0);  chk("stp_idx1", state_idx, 1);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);  chk("stp_idx3", state_idx, 3);
        cyc(0, 0, 0, 0);  chk("stp_idx0", state_idx, 0);
        chk("stp_halted", halted, 1);
        chk("stp_count", instr_count, 5);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0);
            chk("stp_hold", state_idx, 0);
        end
        run = 1'b1;
        #1 chk("run_unhalt", halted, 0);

        // three wait states at fetch2
        cyc(0, 1, 0, 0);  chk("mem_idx1", state_idx, 1);
        stalls = 0;
        for (int i = 0; i < 3; i++) begin
            mem_ready   = 1'b0;
            counter_inc = 1'b1;
            #1;
            if (stall) stalls++;
            @(posedge clk); #1;
            chk("mem_hold", state_idx, 1);
        end
        mem_ready = 1'b1;
        #1 chk("mem_stall_cnt", stalls, 3);
        chk("mem_stall_off", stall, 0);
        cyc(0, 1, 0, 0);  chk("mem_idx2", state_idx, 2);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);  chk("mem_count", instr_count, 6);

        // opcode map
        for (int i = 0; i < 17; i++) begin
            cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
            cyc(1, 0, 0, 5'(map_op[i]));
            chk("map_start", state_idx, map_exp[i]);
            chk("map_legal", illegal_op, 0);
            cyc(0, 0, 1, 0);
        end
        chk("map_count", instr_count, 23);
        chk("map_perr", protocol_err, 0);

        // clr+ld together at fetch3: clr wins, no retire
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        cyc(1, 0, 1, 12); chk("pe_idx0", state_idx, 0);
        chk("pe_set", protocol_err, 1);
        chk("pe_no_done", instr_done, 0);
        cyc(0, 0, 0, 0);  chk("pe_sticky", protocol_err, 1);
        #2 rst_n = 1'b0;
        #1 chk("pe_rst_clr", protocol_err, 0);
        chk("pe_rst_cnt", instr_count, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // inc past last step
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 18); chk("ovf_idx38", state_idx, 38);
        cyc(0, 1, 0, 0);  chk("ovf_idx39", state_idx, 39);
        chk("ovf_perr0", protocol_err, 0);
        cyc(0, 1, 0, 0);  chk("ovf_idx0", state_idx, 0);
        chk("ovf_perr1", protocol_err, 1);
        chk("ovf_count", instr_count, 1);

        // reset mid-instruction at step 14
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 5);  cyc(0, 1, 0, 0);
        chk("mid_idx14", state_idx, 14);
        #2 rst_n = 1'b0;
        #1 chk("mid_idx0", state_idx, 0);
        chk("mid_perr", protocol_err, 0);
        chk("mid_count", instr_count, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        cyc(0, 0, 0, 0);
        chk("mid_no_done", instr_done, 0);
        chk("mid_count2", instr_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
